// File: rtl/spi_pkg.sv
// Shared definitions for the SPI frame-link controller.
//   spi_state_e       : controller FSM states
//   SPI_MSGID_DEFAULT : default expected message-ID header of a received frame
//   SPI_CLK_DIV_MIN   : smallest sclk half-period (clk cycles) the peripheral's
//                       synchronizer can follow
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } spi_state_e;

  localparam logic [31:0]  SPI_MSGID_DEFAULT = 32'h74697277;
  localparam int unsigned  SPI_CLK_DIV_MIN   = 4;

endpackage

// File: rtl/spi_clkgen.sv
// sclk generator for spi_master.
// While en_i is high, sclk toggles every CLK_DIV clk cycles, starting low.
// While en_i is low the half-period count is held at zero and sclk is held
// low, so each enable starts a fresh half-period.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   en_i     : run the generator
//   sclk_o   : registered SPI clock
//   rise_o   : sclk goes high at the end of this cycle (one-cycle strobe)
//   fall_o   : sclk goes low at the end of this cycle (one-cycle strobe)
module spi_clkgen import spi_pkg::*; #(
  parameter int unsigned CLK_DIV = SPI_CLK_DIV_MIN
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             term;

  assign term = (cnt_q == CNT_W'(CLK_DIV - 1));

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en_i) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (term) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;
  assign rise_o = en_i && term && !sclk_q;
  assign fall_o = en_i && term && sclk_q;

endmodule

// File: rtl/spi_master.sv
// SPI controller for the riocore frame link (mode 0, MSB first).
// One start exchanges one full-duplex frame of BUFFER_SIZE bits; the received
// frame is published on rx_data together with a done/valid pulse.
// Optional build macro SPI_MASTER_MSGID_CHECK_EN: when defined, a received
// frame is published (rx_data update + valid) only if its top 32 bits equal
// MSGID; done still pulses for every frame.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   start    : one-cycle frame request, accepted only when idle
//   tx_data  : frame to send, latched on acceptance
//   rx_data  : last published received frame
//   busy     : frame in progress (acceptance through done, inclusive)
//   done     : one-cycle pulse at frame end
//   valid    : one-cycle pulse with done when rx_data was updated
//   sclk     : SPI clock, idles low
//   sel      : chip select, active low
//   mosi     : serial data out
//   miso     : serial data in
module spi_master import spi_pkg::*; #(
  parameter int unsigned BUFFER_SIZE = 64,
  parameter logic [31:0] MSGID       = SPI_MSGID_DEFAULT,
  parameter int unsigned CLK_DIV     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [BUFFER_SIZE-1:0] tx_data,
  output logic [BUFFER_SIZE-1:0] rx_data,
  output logic                   busy,
  output logic                   done,
  output logic                   valid,
  output logic                   sclk,
  output logic                   sel,
  output logic                   mosi,
  input  logic                   miso
);

  localparam int unsigned N      = BUFFER_SIZE;
  // A shorter half-period would outrun the peripheral's synchronizer.
  localparam int unsigned HALF   = (CLK_DIV < SPI_CLK_DIV_MIN) ? SPI_CLK_DIV_MIN : CLK_DIV;
  localparam int          BIT_W  = $clog2(N + 1);
  localparam int          WAIT_W = $clog2(HALF + 1);

`ifdef SPI_MASTER_MSGID_CHECK_EN
  localparam bit ID_CHECK = 1'b1;
`else
  localparam bit ID_CHECK = 1'b0;
`endif

  spi_state_e         state_q, state_d;
  logic [N-1:0]       tx_q, tx_d;
  logic [N-1:0]       rx_q, rx_d;
  logic [N-1:0]       rx_data_q, rx_data_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               sel_q, sel_d;
  logic               mosi_q, mosi_d;
  logic               done_q, done_d;
  logic               valid_q, valid_d;
  logic               sample_q;
  logic               clk_en, rise, fall, sclk_w;
  logic               id_ok;

  // The generator's first half-period doubles as the SETUP wait, so its
  // first rise strobe is also the SETUP -> SHIFT transition.
  assign clk_en = (state_q == ST_SETUP) || (state_q == ST_SHIFT);

  spi_clkgen #(
    .CLK_DIV (HALF)
  ) u_clkgen (
    .clk    (clk),
    .rst    (rst),
    .en_i   (clk_en),
    .sclk_o (sclk_w),
    .rise_o (rise),
    .fall_o (fall)
  );

  assign id_ok = !ID_CHECK || (rx_q[N-1 -: 32] == MSGID);

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    wait_d    = wait_q;
    sel_d     = sel_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;
    valid_d   = 1'b0;

    // miso is captured in the first cycle sclk is high (one cycle after the
    // rise strobe), giving the peripheral's output the longest settle time.
    if (sample_q) begin
      rx_d = {rx_q[N-2:0], miso};
    end

    unique case (state_q)
      ST_IDLE: begin
        wait_d = '0;
        if (start) begin
          state_d   = ST_SETUP;
          tx_d      = tx_data;
          bit_cnt_d = '0;
          sel_d     = 1'b0;
          mosi_d    = tx_data[N-1];
        end
      end
      ST_SETUP: begin
        if (rise) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (fall) begin
          tx_d = {tx_q[N-2:0], 1'b0};
          if (bit_cnt_q == BIT_W'(N - 1)) begin
            state_d = ST_HOLD;
            wait_d  = '0;
            mosi_d  = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            mosi_d    = tx_q[N-2];
          end
        end
      end
      ST_HOLD: begin
        if (wait_q == WAIT_W'(HALF - 1)) begin
          state_d = ST_GAP;
          wait_d  = '0;
          sel_d   = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_GAP: begin
        // GAP spans HALF cycles of sel high plus the done cycle, so a new
        // start cannot be accepted while done is still showing.
        if (wait_q == WAIT_W'(HALF)) begin
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
          if (wait_q == WAIT_W'(HALF - 1)) begin
            done_d  = 1'b1;
            valid_d = id_ok;
            if (id_ok) begin
              rx_data_d = rx_q;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      wait_q    <= '0;
      sel_q     <= 1'b1;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      sample_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      wait_q    <= wait_d;
      sel_q     <= sel_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
      sample_q  <= rise;
    end
  end

  always_ff @(posedge clk) begin
    tx_q <= tx_d;
    rx_q <= rx_d;
  end

  assign rx_data = rx_data_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign valid   = valid_q;
  assign sclk    = sclk_w;
  assign sel     = sel_q;
  assign mosi    = mosi_q;

endmodule

// File: doc/spi_master.md
# spi_master

Controller (initiating) end of the riocore SPI frame link. It drives `sclk`, `sel` and `mosi` toward an SPI peripheral and samples `miso`, exchanging one full-duplex frame of `BUFFER_SIZE` bits per `start`. It checks the received frame's 32-bit message ID header before publishing it. It sits in test harnesses and in FPGA-to-FPGA bridges where the FPGA, rather than a host CPU, owns the bus.

## Interface
Parameters:
- `BUFFER_SIZE`, 64: frame length in bits; minimum 33.
- `MSGID`, 32'h74697277: required value of received bits `[BUFFER_SIZE-1:BUFFER_SIZE-32]`.
- `CLK_DIV`, 4: `sclk` half-period in `clk` cycles; minimum 4, which covers the peripheral's synchronizer latency.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: single-cycle request to send a frame; accepted only in IDLE.
- `tx_data` input `BUFFER_SIZE`: frame to transmit, MSB first; latched on acceptance.
- `rx_data` output `BUFFER_SIZE`: last accepted received frame.
- `busy` output 1: high from acceptance until `done`, inclusive.
- `done` output 1: one-cycle pulse at frame end.
- `valid` output 1: one-cycle pulse coincident with `done` when `rx_data` was updated.
- `sclk` output 1: SPI clock; idles low (mode 0).
- `sel` output 1: chip select, active low.
- `mosi` output 1: serial data out.
- `miso` input 1: serial data in.

## Operation
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE -> SETUP on `start`:
  - latch `tx_data` into the shift register;
  - drive `sel`=0 and `mosi`=tx MSB.
- SETUP: wait `CLK_DIV` cycles, then -> SHIFT.
- SHIFT: `sclk` toggles every `CLK_DIV` cycles for `BUFFER_SIZE` bits.
  - Rising edge: sample `miso` into the receive shift register.
  - Falling edge: shift tx left and present the next bit on `mosi`.
  - After the `BUFFER_SIZE`-th falling edge -> HOLD.
- HOLD: `sclk`=0 for `CLK_DIV` cycles, then `sel`=1 -> GAP.
- GAP: `CLK_DIV` cycles so the peripheral detects the `sel` rising edge.
  - Then pulse `done`, publish the received frame (see Configuration), and -> IDLE.
- `start` while not in IDLE is ignored; it is not queued.
- `mosi` is 0 whenever `sel`=1.
- Reset values: IDLE, `sel`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `valid`=0, `rx_data`=0.
- Reset mid-frame: all of the above apply on the next edge; the partial frame is discarded and `rx_data` is zeroed.
- `rst` and `start` high in the same cycle: reset wins.

## Timing
- Let T0 be the cycle `start` is sampled in IDLE, C=`CLK_DIV`, N=`BUFFER_SIZE`.
- T0+1: `sel`=0, `busy`=1, `mosi`=tx[N-1].
- Rising edge k (k=0..N-1): at T0+1+C+2kC; `miso` is sampled in that cycle.
- Falling edge k: at T0+1+2(k+1)C.
- Last falling edge: T0+1+2NC.
- `sel`=1: T0+1+2NC+C.
- `done` and `valid` pulse, `rx_data` updates: T0+1+2NC+2C. `busy` drops the following cycle.
- Defaults (N=64, C=4): `done` at T0+521.
- A new `start` is accepted from T0+2NC+2C+2 onward; the minimum frame period is 2NC+2C+2 cycles.

## Configuration
- `SPI_MASTER_MSGID_CHECK_EN` defined:
  - `rx_data` updates and `valid` pulses only if received bits `[N-1:N-32]` == `MSGID`;
  - otherwise `rx_data` holds its previous value, `valid` stays 0, and `done` still pulses.
- Undefined: every completed frame updates `rx_data` and pulses `valid` with `done`.

## Structure
- Package `spi_pkg`: FSM state enum, default `MSGID` constant, minimum-`CLK_DIV` constant.
- Sub-module `spi_clkgen`:
  - half-period counter enabled by the FSM;
  - emits one-cycle `rise`/`fall` strobes and the registered `sclk`;
  - resets its count on enable.
- Top level: FSM, tx/rx shift registers, bit counter (width `$clog2(BUFFER_SIZE+1)`).

## Test plan
- Reset, then idle 100 cycles -> `sel`=1, `sclk`=0, `mosi`=0, `busy`=0, `rx_data`=0.
- Loopback `miso`=`mosi`, tx=64'h74697277_DEADBEEF, start at T0 -> `done`+`valid` at T0+521, `rx_data`=64'h74697277_DEADBEEF, exactly 64 rising edges.
- With the check compiled in and `miso` tied 0 -> `done` pulses, `valid`=0, `rx_data` unchanged from the previous frame.
- Bench peripheral model (2-flop sync on `sclk`/`sel`, shifts on `sclk` fall) preloaded with 64'h74697277_00000042, C=4 -> `rx_data` equals the preload, and the peripheral captures the master's tx frame.
- `start` pulsed at T0+10 and T0+300 -> ignored, one frame only. Then `rst` at T0+200 -> next cycle `sel`=1, `sclk`=0, `busy`=0, no `done`.
- Back-to-back `start` at the earliest accepted cycle after `done` -> `sel` high for at least C cycles between frames, both frames correct.
